// File: rtl/his_ctrl_pkg.sv
// Shared types and sizing helpers for the histogram pass scheduler.
// State encoding, pass encoding and counter-width functions.
package his_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR0   = 3'd1,
        S_COARSE = 3'd2,
        S_PEAKW  = 3'd3,
        S_CLR1   = 3'd4,
        S_FINE   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef enum logic {
        PASS_COARSE = 1'b0,
        PASS_FINE   = 1'b1
    } pass_t;

    // A counter for n values never collapses below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/his_nested_counter.sv
// Sample/pixel/acquisition counter chain with wrap-carry and a last-sample flag.
module his_nested_counter
    import his_ctrl_pkg::*;
#(
    parameter int DATA_NUM  = 2,
    parameter int PIXEL_NUM = 4,
    parameter int ACQ_NUM   = 16
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          clr,
    input  logic                          inc,
    output logic [cnt_w(PIXEL_NUM)-1:0]   pix,
    output logic                          last
);

    localparam int IN_W  = cnt_w(DATA_NUM);
    localparam int PIX_W = cnt_w(PIXEL_NUM);
    localparam int ACQ_W = cnt_w(ACQ_NUM);

    logic [IN_W-1:0]  in_q;
    logic [PIX_W-1:0] pix_q;
    logic [ACQ_W-1:0] acq_q;
    logic             in_max, pix_max, acq_max;

    assign in_max  = (in_q  == IN_W'(DATA_NUM - 1));
    assign pix_max = (pix_q == PIX_W'(PIXEL_NUM - 1));
    assign acq_max = (acq_q == ACQ_W'(ACQ_NUM - 1));
    assign last    = in_max & pix_max & acq_max;
    assign pix     = pix_q;

    always_ff @(posedge clk) begin
        if (res || clr) begin
            in_q  <= '0;
            pix_q <= '0;
            acq_q <= '0;
        end else if (inc) begin
            if (in_max) begin
                in_q <= '0;
                if (pix_max) begin
                    pix_q <= '0;
                    acq_q <= acq_max ? '0 : acq_q + 1'b1;
                end else begin
                    pix_q <= pix_q + 1'b1;
                end
            end else begin
                in_q <= in_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/his_pass_scheduler.sv
// Two-pass (coarse -> fine) histogram acquisition sequencer for one histogram RAM.
// Optional peak-wait timeout and sticky err_tmo when PEAK_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start
// CLR0     | clearing bin RAM before coarse pass
// COARSE   | gating samples into coarse histogram
// PEAKW    | waiting for builder peak search
// CLR1     | clearing bin RAM before fine pass
// FINE     | gating samples into fine histogram
// DONE     | one-cycle frame_done
module his_pass_scheduler
    import his_ctrl_pkg::*;
#(
    parameter int NP        = 12,
    parameter int NB        = 8,
    parameter int DATA_NUM  = 2,
    parameter int PIXEL_NUM = 4,
    parameter int ACQ_NUM   = 16,
    parameter int CLR_CYC   = 256,
    parameter int PEAK_TMO  = 1024
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         tdc_valid,
    input  logic [NP-1:0]                tdc_data,
    output logic                         tdc_ready,
    output logic                         his_wr_en,
    output logic [NP-1:0]                his_data,
    output logic [cnt_w(PIXEL_NUM)-1:0]  his_pixel,
    output logic                         his_pass,
    output logic                         his_clr,
    input  logic                         peak_done,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_tmo
);

    // Clear is never shorter than one pixel's worth of bins.
    localparam int CLR_LEN = max_i(CLR_CYC, 2 ** NB);
    localparam int TMR_W   = cnt_w(max_i(CLR_LEN, PEAK_TMO));
    localparam int PIX_W   = cnt_w(PIXEL_NUM);
    localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_LEN - 1);

    state_t            state_q, state_nxt;
    logic [TMR_W-1:0]  tmr_q, tmr_nxt;
    logic              tmr_zero, accept, last;
    logic [PIX_W-1:0]  pix_cnt;

    assign tdc_ready  = (state_q == S_COARSE) || (state_q == S_FINE);
    assign accept     = tdc_valid & tdc_ready;
    assign his_clr    = (state_q == S_CLR0) || (state_q == S_CLR1);
    assign his_pass   = ((state_q == S_CLR1) || (state_q == S_FINE) || (state_q == S_DONE))
                        ? PASS_FINE : PASS_COARSE;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign tmr_zero   = (tmr_q == '0);

    his_nested_counter #(
        .DATA_NUM  (DATA_NUM),
        .PIXEL_NUM (PIXEL_NUM),
        .ACQ_NUM   (ACQ_NUM)
    ) u_cnt (
        .clk  (clk),
        .res  (res),
        .clr  (~tdc_ready),
        .inc  (accept),
        .pix  (pix_cnt),
        .last (last)
    );

`ifdef PEAK_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(PEAK_TMO - 1);
    logic err_set, start_go, err_q;
`endif

    always_comb begin
        state_nxt = state_q;
        tmr_nxt   = tmr_q;
`ifdef PEAK_TIMEOUT_EN
        err_set   = 1'b0;
        start_go  = 1'b0;
`endif
        if (abort && (state_q != S_IDLE)) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start && !abort) begin
                    state_nxt = S_CLR0;
                    tmr_nxt   = CLR_LOAD;
`ifdef PEAK_TIMEOUT_EN
                    start_go  = 1'b1;
`endif
                end
                S_CLR0: if (tmr_zero) state_nxt = S_COARSE;
                        else          tmr_nxt   = tmr_q - 1'b1;
                S_COARSE: if (accept && last) begin
                    state_nxt = S_PEAKW;
`ifdef PEAK_TIMEOUT_EN
                    tmr_nxt   = TMO_LOAD;
`endif
                end
                S_PEAKW: if (peak_done) begin
                    state_nxt = S_CLR1;
                    tmr_nxt   = CLR_LOAD;
                end
`ifdef PEAK_TIMEOUT_EN
                else if (tmr_zero) begin
                    state_nxt = S_IDLE;
                    err_set   = 1'b1;
                end else begin
                    tmr_nxt   = tmr_q - 1'b1;
                end
`endif
                S_CLR1: if (tmr_zero) state_nxt = S_FINE;
                        else          tmr_nxt   = tmr_q - 1'b1;
                S_FINE: if (accept && last) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_nxt;
            tmr_q   <= tmr_nxt;
        end
    end

    // A sample accepted on the abort cycle is dropped; one already registered still issues.
    always_ff @(posedge clk) begin
        if (res) begin
            his_wr_en <= 1'b0;
            his_data  <= '0;
            his_pixel <= '0;
        end else begin
            his_wr_en <= accept & ~abort;
            if (accept) begin
                his_data  <= tdc_data;
                his_pixel <= pix_cnt;
            end
        end
    end

`ifdef PEAK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (res)           err_q <= 1'b0;
        else if (err_set)  err_q <= 1'b1;
        else if (start_go) err_q <= 1'b0;
    end
    assign err_tmo = err_q;
`else
    assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_his_pass_scheduler.sv
// Randomized self-checking bench for his_pass_scheduler against a pass-level reference model.
module tb_his_pass_scheduler;

    localparam int NP        = 12;
    localparam int DATA_NUM  = 2;
    localparam int PIXEL_NUM = 4;
    localparam int ACQ_NUM   = 16;
    localparam int CLR_CYC   = 256;
    localparam int TOTAL     = DATA_NUM * PIXEL_NUM * ACQ_NUM;
`ifdef PEAK_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic          clk, res, start, abort, tdc_valid, peak_done;
    logic [NP-1:0] tdc_data, his_data;
    logic          tdc_ready, his_wr_en, his_pass, his_clr, busy, frame_done, err_tmo;
    logic [1:0]    his_pixel;

    his_pass_scheduler #(
        .NP(NP), .NB(8), .DATA_NUM(DATA_NUM), .PIXEL_NUM(PIXEL_NUM),
        .ACQ_NUM(ACQ_NUM), .CLR_CYC(CLR_CYC), .PEAK_TMO(TMO)
    ) dut (
        .clk(clk), .res(res), .start(start), .abort(abort),
        .tdc_valid(tdc_valid), .tdc_data(tdc_data), .tdc_ready(tdc_ready),
        .his_wr_en(his_wr_en), .his_data(his_data), .his_pixel(his_pixel),
        .his_pass(his_pass), .his_clr(his_clr), .peak_done(peak_done),
        .busy(busy), .frame_done(frame_done), .err_tmo(err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model phases: 0 idle, 1 clear-coarse, 2 coarse, 3 peak wait, 4 clear-fine, 5 fine, 6 done
    int            m_ph, m_cnt, m_acc, m_pix;
    logic          m_wr, m_err;
    logic [NP-1:0] m_data;

    int n_vec, n_err, duty;
    int c_wr0, c_wr1, c_clr, c_fd;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic acc;
        acc = tdc_valid && (m_ph == 2 || m_ph == 5);
        if (res) begin
            m_ph = 0; m_cnt = 0; m_acc = 0; m_pix = 0;
            m_wr = 1'b0; m_err = 1'b0; m_data = '0;
            return;
        end
        m_wr = acc && !abort;
        if (acc) begin
            m_data = tdc_data;
            m_pix  = (m_acc / DATA_NUM) % PIXEL_NUM;
        end
        if (abort && m_ph != 0) begin
            m_ph = 0; m_cnt = 0; m_acc = 0;
            return;
        end
        case (m_ph)
            0: if (start) begin m_ph = 1; m_cnt = 0; m_err = 1'b0; end
            1, 4: begin
                m_cnt++;
                if (m_cnt == CLR_CYC) begin m_ph++; m_cnt = 0; m_acc = 0; end
            end
            2, 5: if (acc) begin
                m_acc++;
                if (m_acc == TOTAL) begin m_acc = 0; m_ph++; m_cnt = 0; end
            end
            3: if (peak_done) begin
                m_ph = 4; m_cnt = 0;
            end else begin
`ifdef PEAK_TIMEOUT_EN
                m_cnt++;
                if (m_cnt == TMO) begin m_err = 1'b1; m_ph = 0; end
`endif
            end
            6: m_ph = 0;
            default: ;
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk_eq("busy", busy, m_ph != 0);
        chk_eq("tdc_ready", tdc_ready, m_ph == 2 || m_ph == 5);
        chk_eq("his_clr", his_clr, m_ph == 1 || m_ph == 4);
        chk_eq("his_pass", his_pass, m_ph >= 4);
        chk_eq("frame_done", frame_done, m_ph == 6);
        chk_eq("his_wr_en", his_wr_en, m_wr);
        chk_eq("err_tmo", err_tmo, m_err);
        if (m_wr) begin
            chk_eq("his_data", his_data, m_data);
            chk_eq("his_pixel", his_pixel, m_pix);
        end
        if (his_wr_en) begin
            if (his_pass) c_wr1++;
            else          c_wr0++;
        end
        if (his_clr)    c_clr++;
        if (frame_done) c_fd++;
        tdc_data  = NP'($urandom);
        tdc_valid = ($urandom_range(99) < duty);
    endtask

    task automatic run_until(input int ph, input int budget);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin
            cyc();
            n++;
        end
        chk_eq("phase_reached", m_ph, ph);
    endtask

    task automatic clr_counts();
        c_wr0 = 0; c_wr1 = 0; c_clr = 0; c_fd = 0;
    endtask

    task automatic full_frame();
        clr_counts();
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_until(3, 20000);
        repeat (10) cyc();
        peak_done = 1'b1;
        cyc();
        peak_done = 1'b0;
        run_until(0, 20000);
        chk_eq("coarse_writes", c_wr0, TOTAL);
        chk_eq("fine_writes", c_wr1, TOTAL);
        chk_eq("clr_cycles", c_clr, 2 * CLR_CYC);
        chk_eq("frame_done_cnt", c_fd, 1);
    endtask

    initial begin
        n_vec = 0; n_err = 0; duty = 100;
        res = 1'b1; start = 1'b0; abort = 1'b0; peak_done = 1'b0;
        tdc_valid = 1'b0; tdc_data = '0;
        m_ph = 0; m_cnt = 0; m_acc = 0; m_pix = 0; m_wr = 1'b0; m_err = 1'b0; m_data = '0;
        clr_counts();

        repeat (3) cyc();
        res = 1'b0;
        cyc();
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_ready", tdc_ready, 0);

        // full frame, valid always high
        duty = 100;
        full_frame();

        // sparse valid
        duty = 30;
        full_frame();

        // abort mid-coarse, then a clean restart
        duty = 100;
        clr_counts();
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_until(2, 1000);
        for (int n = 0; n < 500 && m_acc < 50; n++) cyc();
        tdc_valid = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        tdc_valid = 1'b0;
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_wr", his_wr_en, 0);
        chk_eq("abort_clr", his_clr, 0);
        chk_eq("abort_writes", c_wr0, 50);
        repeat (5) cyc();
        chk_eq("abort_no_fd", c_fd, 0);
        full_frame();

        // reset in the middle of the fine pass
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_until(3, 20000);
        peak_done = 1'b1;
        cyc();
        peak_done = 1'b0;
        run_until(5, 1000);
        repeat (20) cyc();
        res = 1'b1;
        repeat (3) cyc();
        chk_eq("res_busy", busy, 0);
        chk_eq("res_ready", tdc_ready, 0);
        chk_eq("res_wr", his_wr_en, 0);
        chk_eq("res_pass", his_pass, 0);
        chk_eq("res_data", his_data, 0);
        res = 1'b0;
        cyc();

        // start held high, stray peak_done during coarse
        clr_counts();
        duty = 60;
        start = 1'b1;
        cyc();
        for (int n = 0; n < 20000 && m_ph != 3; n++) begin
            peak_done = (m_ph == 2) && ($urandom_range(3) == 0);
            cyc();
        end
        peak_done = 1'b0;
        chk_eq("t5_peakw", m_ph, 3);
        repeat (20) cyc();
        chk_eq("t5_no_clr1", his_clr, 0);
        chk_eq("t5_busy", busy, 1);
        peak_done = 1'b1;
        cyc();
        peak_done = 1'b0;
        run_until(6, 20000);
        start = 1'b0;
        run_until(0, 10);
        repeat (5) cyc();
        chk_eq("t5_fd_cnt", c_fd, 1);
        chk_eq("t5_coarse", c_wr0, TOTAL);
        chk_eq("t5_fine", c_wr1, TOTAL);

`ifdef PEAK_TIMEOUT_EN
        // peak-wait timeout
        clr_counts();
        duty = 100;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_until(3, 20000);
        run_until(0, TMO + 4);
        chk_eq("tmo_err", err_tmo, 1);
        chk_eq("tmo_busy", busy, 0);
        chk_eq("tmo_no_fd", c_fd, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_eq("tmo_clear", err_tmo, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
